// File: rtl/segment_history_pkg.sv
// segment_history_pkg: shared spbits widths and depths for the segment history slice
//   bw_fph/bw_th : phi/theta widths, seg_ch : segments per chamber,
//   max_drift    : BX history depth, cnt_w : cancel counter width
package segment_history_pkg;
    localparam int bw_fph    = 13;
    localparam int bw_th     = 7;
    localparam int seg_ch    = 2;
    localparam int max_drift = 3;
    localparam int cnt_w     = 16;
    // station 0 is the ME1/1 index and carries four theta values per chamber
    function automatic int default_zone_seg(input int station);
        return (station == 0) ? 4 : 2;
    endfunction
endpackage

// File: rtl/segment_history_if.sv
// segment_history_if: current-BX segment inputs, matcher feedback and history outputs
//   master drives flush, ph/ph_v/th/cpat inputs and m_* match feedback
//   slave  drives the ph/ph_v/th/cpat history and cancel_cnt
interface segment_history_if #(
    parameter int zone_cham = 6,
    parameter int zone_seg  = 2
);
    import segment_history_pkg::*;
    logic                flush;
    logic [bw_fph-1:0]   ph_in      [zone_cham][seg_ch];
    logic [seg_ch-1:0]   ph_v_in    [zone_cham];
    logic [bw_th-1:0]    th_in      [zone_cham][zone_seg];
    logic [3:0]          cpat_in    [zone_cham][seg_ch];
    logic [seg_ch-1:0]   m_vid;
    logic [1:0]          m_hid;
    logic [2:0]          m_cid;
    logic                m_sid;
    logic [bw_fph-1:0]   ph_seg_p   [max_drift][zone_cham][seg_ch];
    logic [seg_ch-1:0]   ph_seg_v_p [max_drift][zone_cham];
    logic [bw_th-1:0]    th_seg_p   [max_drift][zone_cham][zone_seg];
    logic [3:0]          cpat_seg_p [max_drift][zone_cham][seg_ch];
    logic [cnt_w-1:0]    cancel_cnt;
    modport master (
        output flush, ph_in, ph_v_in, th_in, cpat_in, m_vid, m_hid, m_cid, m_sid,
        input  ph_seg_p, ph_seg_v_p, th_seg_p, cpat_seg_p, cancel_cnt
    );
    modport slave (
        input  flush, ph_in, ph_v_in, th_in, cpat_in, m_vid, m_hid, m_cid, m_sid,
        output ph_seg_p, ph_seg_v_p, th_seg_p, cpat_seg_p, cancel_cnt
    );
endinterface

// File: rtl/segment_history_seg_hist_stage.sv
// seg_hist_stage: one BX depth of segment history with per-bit valid clear
//   clk, rst_n : clock, async active-low reset
//   flush      : zero all valid bits on load
//   *_d        : previous depth (or current BX) data, clr : valid bits to drop
//   *_q        : registered depth contents
module seg_hist_stage
    import segment_history_pkg::*;
#(
    parameter int zone_cham = 6,
    parameter int zone_seg  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [bw_fph-1:0] ph_d   [zone_cham][seg_ch],
    input  logic [seg_ch-1:0] v_d    [zone_cham],
    input  logic [seg_ch-1:0] clr    [zone_cham],
    input  logic [bw_th-1:0]  th_d   [zone_cham][zone_seg],
    input  logic [3:0]        cpat_d [zone_cham][seg_ch],
    output logic [bw_fph-1:0] ph_q   [zone_cham][seg_ch],
    output logic [seg_ch-1:0] v_q    [zone_cham],
    output logic [bw_th-1:0]  th_q   [zone_cham][zone_seg],
    output logic [3:0]        cpat_q [zone_cham][seg_ch]
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q   <= '{default: '0};
            v_q    <= '{default: '0};
            th_q   <= '{default: '0};
            cpat_q <= '{default: '0};
        end else begin
            ph_q   <= ph_d;
            th_q   <= th_d;
            cpat_q <= cpat_d;
            for (int c = 0; c < zone_cham; c++)
                v_q[c] <= flush ? '0 : v_d[c] & ~clr[c];
        end
    end
endmodule

// File: rtl/segment_history.sv
// segment_history: max_drift-deep BX history of segments with ghost cancellation
//   clk, rst_n : BX clock, async active-low reset
//   bus        : slave side of segment_history_if (inputs, match feedback, history)
module segment_history
    import segment_history_pkg::*;
#(
    parameter int station   = 1,
    parameter int zone_cham = 6,
    parameter int zone_seg  = default_zone_seg(station)
) (
    input  logic              clk,
    input  logic              rst_n,
    segment_history_if.slave  bus
);
    logic [bw_fph-1:0] ph_h   [max_drift][zone_cham][seg_ch];
    logic [bw_fph-1:0] ph_s   [max_drift][zone_cham][seg_ch];
    logic [seg_ch-1:0] v_h    [max_drift][zone_cham];
    logic [seg_ch-1:0] v_s    [max_drift][zone_cham];
    logic [seg_ch-1:0] clr    [max_drift][zone_cham];
    logic [bw_th-1:0]  th_h   [max_drift][zone_cham][zone_seg];
    logic [bw_th-1:0]  th_s   [max_drift][zone_cham][zone_seg];
    logic [3:0]        cpat_h [max_drift][zone_cham][seg_ch];
    logic [3:0]        cpat_s [max_drift][zone_cham][seg_ch];
    logic [cnt_w-1:0]  cnt;
    logic              legal;
    logic              hit;
    int                h;
    // The match names the pre-shift depth m_hid; after this edge that entry sits at m_hid+1,
    // so the clear is applied on the load into stage m_hid+1 and the hit test reads its source.
    always_comb begin
        h         = int'(bus.m_hid) + 1;
        legal     = |bus.m_vid && !bus.flush && h < max_drift && int'(bus.m_cid) < zone_cham;
        hit       = 1'b0;
        ph_s[0]   = bus.ph_in;
        v_s[0]    = bus.ph_v_in;
        th_s[0]   = bus.th_in;
        cpat_s[0] = bus.cpat_in;
        for (int d = 1; d < max_drift; d++) begin
            ph_s[d]   = ph_h[d-1];
            v_s[d]    = v_h[d-1];
            th_s[d]   = th_h[d-1];
            cpat_s[d] = cpat_h[d-1];
        end
        for (int d = 0; d < max_drift; d++)
            for (int c = 0; c < zone_cham; c++)
                for (int s = 0; s < seg_ch; s++) begin
                    clr[d][c][s] = legal && d == h && c == int'(bus.m_cid) && s == int'(bus.m_sid);
                    hit          = hit | (clr[d][c][s] & v_s[d][c][s]);
                end
    end
    for (genvar d = 0; d < max_drift; d++) begin : g_stage
        seg_hist_stage #(.zone_cham(zone_cham), .zone_seg(zone_seg)) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .flush  (bus.flush),
            .ph_d   (ph_s[d]),
            .v_d    (v_s[d]),
            .clr    (clr[d]),
            .th_d   (th_s[d]),
            .cpat_d (cpat_s[d]),
            .ph_q   (ph_h[d]),
            .v_q    (v_h[d]),
            .th_q   (th_h[d]),
            .cpat_q (cpat_h[d])
        );
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (hit && cnt != '1) cnt <= cnt + 1'b1;
    end
    assign bus.ph_seg_p   = ph_h;
    assign bus.ph_seg_v_p = v_h;
    assign bus.th_seg_p   = th_h;
    assign bus.cpat_seg_p = cpat_h;
    assign bus.cancel_cnt = cnt;
endmodule

// File: tb/tb_segment_history.sv
// tb_segment_history: directed scenario bench for segment_history
module tb_segment_history;
    import segment_history_pkg::*;
    localparam int zc = 6;
    localparam int zs = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    segment_history_if #(.zone_cham(zc), .zone_seg(zs)) bus ();
    segment_history #(.station(1), .zone_cham(zc), .zone_seg(zs)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.flush = 1'b0;
        bus.m_vid = '0;
        bus.m_hid = '0;
        bus.m_cid = '0;
        bus.m_sid = 1'b0;
        for (int c = 0; c < zc; c++) begin
            bus.ph_v_in[c] = '0;
            for (int s = 0; s < seg_ch; s++) begin
                bus.ph_in[c][s]   = '0;
                bus.cpat_in[c][s] = '0;
            end
            for (int t = 0; t < zs; t++) bus.th_in[c][t] = '0;
        end
    endtask

    task automatic set_match(input logic [1:0] vid, input logic [1:0] hid,
                             input logic [2:0] cid, input logic sid);
        bus.m_vid = vid;
        bus.m_hid = hid;
        bus.m_cid = cid;
        bus.m_sid = sid;
    endtask

    function automatic int count_valid();
        int n = 0;
        for (int d = 0; d < max_drift; d++)
            for (int c = 0; c < zc; c++)
                if (bus.ph_seg_v_p[d][c] != 0) n++;
        return n;
    endfunction

    function automatic int count_nonzero();
        int n = 0;
        for (int d = 0; d < max_drift; d++)
            for (int c = 0; c < zc; c++) begin
                if (bus.ph_seg_v_p[d][c] != 0) n++;
                for (int s = 0; s < seg_ch; s++) begin
                    if (bus.ph_seg_p[d][c][s] != 0) n++;
                    if (bus.cpat_seg_p[d][c][s] != 0) n++;
                end
                for (int t = 0; t < zs; t++)
                    if (bus.th_seg_p[d][c][t] != 0) n++;
            end
        if (bus.cancel_cnt != 0) n++;
        return n;
    endfunction

    task automatic test_reset();
        #1;
        checks++;
        if (count_nonzero() !== 0) begin
            errors++;
            $display("FAIL reset_zero: %0d nonzero fields, want 0", count_nonzero());
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_shift_latency();
        bus.ph_in[2][1]   = 13'd1000;
        bus.ph_v_in[2]    = 2'b10;
        bus.th_in[2][1]   = 7'd55;
        bus.cpat_in[2][1] = 4'd9;
        tick();
        idle();
        checks++;
        if (bus.ph_seg_p[0][2][1] !== 13'd1000 || bus.ph_seg_v_p[0][2] !== 2'b10) begin
            errors++;
            $display("FAIL shift_d0: ph %0d v %b, want 1000 10", bus.ph_seg_p[0][2][1], bus.ph_seg_v_p[0][2]);
        end
        tick();
        checks++;
        if (bus.ph_seg_p[1][2][1] !== 13'd1000 || bus.ph_seg_v_p[1][2] !== 2'b10 || bus.ph_seg_v_p[0][2] !== 2'b00) begin
            errors++;
            $display("FAIL shift_d1: ph %0d v1 %b v0 %b, want 1000 10 00",
                     bus.ph_seg_p[1][2][1], bus.ph_seg_v_p[1][2], bus.ph_seg_v_p[0][2]);
        end
        tick();
        checks++;
        if (bus.ph_seg_v_p[2][2] !== 2'b10 || bus.th_seg_p[2][2][1] !== 7'd55 || bus.cpat_seg_p[2][2][1] !== 4'd9) begin
            errors++;
            $display("FAIL shift_d2: v %b th %0d cpat %0d, want 10 55 9",
                     bus.ph_seg_v_p[2][2], bus.th_seg_p[2][2][1], bus.cpat_seg_p[2][2][1]);
        end
        tick();
        checks++;
        if (count_valid() !== 0) begin
            errors++;
            $display("FAIL shift_gone: %0d valid chambers, want 0", count_valid());
        end
    endtask

    task automatic test_cancel();
        bus.ph_in[2][1] = 13'd1000;
        bus.ph_v_in[2]  = 2'b11;
        tick();
        idle();
        set_match(2'b01, 2'd0, 3'd2, 1'b1);
        tick();
        idle();
        checks++;
        if (bus.ph_seg_v_p[1][2] !== 2'b01 || bus.ph_seg_p[1][2][1] !== 13'd1000 || bus.cancel_cnt !== 16'd1) begin
            errors++;
            $display("FAIL cancel: v %b ph %0d cnt %0d, want 01 1000 1",
                     bus.ph_seg_v_p[1][2], bus.ph_seg_p[1][2][1], bus.cancel_cnt);
        end
    endtask

    task automatic test_shifted_out();
        bus.ph_v_in[2] = 2'b11;
        tick();
        idle();
        tick();
        set_match(2'b01, 2'd2, 3'd2, 1'b1);
        tick();
        idle();
        checks++;
        if (bus.ph_seg_v_p[2][2] !== 2'b11 || bus.cancel_cnt !== 16'd1) begin
            errors++;
            $display("FAIL shifted_out: v %b cnt %0d, want 11 1", bus.ph_seg_v_p[2][2], bus.cancel_cnt);
        end
    endtask

    task automatic test_illegal();
        bus.ph_v_in[2] = 2'b11;
        tick();
        idle();
        set_match(2'b01, 2'd0, 3'd7, 1'b1);
        tick();
        idle();
        checks++;
        if (bus.ph_seg_v_p[1][2] !== 2'b11 || bus.cancel_cnt !== 16'd1) begin
            errors++;
            $display("FAIL illegal_cid: v %b cnt %0d, want 11 1", bus.ph_seg_v_p[1][2], bus.cancel_cnt);
        end
        bus.ph_v_in[2] = 2'b10;
        tick();
        idle();
        set_match(2'b10, 2'd0, 3'd2, 1'b1);
        tick();
        idle();
        checks++;
        if (bus.ph_seg_v_p[1][2] !== 2'b00 || bus.cancel_cnt !== 16'd2) begin
            errors++;
            $display("FAIL second_cancel: v %b cnt %0d, want 00 2", bus.ph_seg_v_p[1][2], bus.cancel_cnt);
        end
        set_match(2'b01, 2'd1, 3'd2, 1'b1);
        tick();
        idle();
        checks++;
        if (bus.ph_seg_v_p[2][2] !== 2'b00 || bus.cancel_cnt !== 16'd2) begin
            errors++;
            $display("FAIL repeat_match: v %b cnt %0d, want 00 2", bus.ph_seg_v_p[2][2], bus.cancel_cnt);
        end
    endtask

    task automatic test_flush();
        bus.ph_in[2][1] = 13'd1000;
        bus.ph_v_in[2]  = 2'b11;
        tick();
        idle();
        bus.flush       = 1'b1;
        bus.ph_in[2][1] = 13'd777;
        for (int c = 0; c < zc; c++) bus.ph_v_in[c] = 2'b11;
        set_match(2'b01, 2'd0, 3'd2, 1'b1);
        tick();
        idle();
        checks++;
        if (count_valid() !== 0 || bus.cancel_cnt !== 16'd2) begin
            errors++;
            $display("FAIL flush_valid: %0d valid chambers cnt %0d, want 0 2", count_valid(), bus.cancel_cnt);
        end
        checks++;
        if (bus.ph_seg_p[1][2][1] !== 13'd1000 || bus.ph_seg_p[0][2][1] !== 13'd777) begin
            errors++;
            $display("FAIL flush_data: ph1 %0d ph0 %0d, want 1000 777", bus.ph_seg_p[1][2][1], bus.ph_seg_p[0][2][1]);
        end
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.cancel_cnt !== 16'd0) begin
            errors++;
            $display("FAIL sat_start: cnt %0d, want 0", bus.cancel_cnt);
        end
        bus.ph_v_in[0] = 2'b01;
        set_match(2'b01, 2'd0, 3'd0, 1'b0);
        repeat (65535) tick();
        checks++;
        if (bus.cancel_cnt !== 16'hfffe || bus.ph_seg_v_p[1][0] !== 2'b00) begin
            errors++;
            $display("FAIL sat_fffe: cnt %h v %b, want fffe 00", bus.cancel_cnt, bus.ph_seg_v_p[1][0]);
        end
        tick();
        checks++;
        if (bus.cancel_cnt !== 16'hffff) begin
            errors++;
            $display("FAIL sat_ffff: cnt %h, want ffff", bus.cancel_cnt);
        end
        repeat (2) tick();
        checks++;
        if (bus.cancel_cnt !== 16'hffff) begin
            errors++;
            $display("FAIL sat_hold: cnt %h, want ffff", bus.cancel_cnt);
        end
        idle();
    endtask

    task automatic test_async_reset();
        bus.ph_in[3][0] = 13'd123;
        bus.ph_v_in[3]  = 2'b01;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count_nonzero() !== 0) begin
            errors++;
            $display("FAIL async_reset: %0d nonzero fields, want 0", count_nonzero());
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        bus.ph_in[4][0] = 13'h1abc;
        bus.ph_v_in[4]  = 2'b01;
        #1;
        checks++;
        if (bus.ph_seg_v_p[0][4] !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_early: v %b, want 00", bus.ph_seg_v_p[0][4]);
        end
        tick();
        checks++;
        if (bus.ph_seg_p[0][4][0] !== 13'h1abc || bus.ph_seg_v_p[0][4] !== 2'b01 || bus.cancel_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_reset_load: ph %h v %b cnt %0d, want 1abc 01 0",
                     bus.ph_seg_p[0][4][0], bus.ph_seg_v_p[0][4], bus.cancel_cnt);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_shift_latency();
        test_cancel();
        test_shifted_out();
        test_illegal();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
